// File: rtl/div_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl_if
// Handshake and data bundle between the divide sequencer (master) and the
// iterative divider (slave).
//   div_start   master->slave  keep dividing while high
//   div_abandon master->slave  drop the operation in progress
//   div_stall   master->slave  hold the End state while the pipeline is stalled
//   div_signdiv master->slave  1 = signed divide
//   div_opr1    master->slave  dividend
//   div_opr2    master->slave  divisor
//   div_ready   slave->master  result valid this cycle
//   div_res     slave->master  {remainder, quotient}
// -----------------------------------------------------------------------------
interface div_seq_ctrl_if;
  logic        div_start;
  logic        div_abandon;
  logic        div_stall;
  logic        div_signdiv;
  logic [31:0] div_opr1;
  logic [31:0] div_opr2;
  logic        div_ready;
  logic [63:0] div_res;

  modport master (
    output div_start, div_abandon, div_stall, div_signdiv, div_opr1, div_opr2,
    input  div_ready, div_res
  );

  modport slave (
    input  div_start, div_abandon, div_stall, div_signdiv, div_opr1, div_opr2,
    output div_ready, div_res
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Sequencer between the EX stage and the iterative divider. Decodes DIV/DIVU
// and MTHI/MTLO, latches divide operands, runs the divider handshake, stalls
// EX while a quotient is outstanding and owns the architectural HI/LO.
//   clk, rst        clock, synchronous active-high reset
//   ex_valid_i      valid instruction in EX
//   ex_op_i         1 DIV, 2 DIVU, 3 MTHI, 4 MTLO, other = no-op
//   ex_opr1_i       dividend / MTHI-MTLO source
//   ex_opr2_i       divisor
//   flush_i         EX flush
//   pipe_stall_i    downstream stall
//   ex_stallreq_o   EX stall request (combinational)
//   hi_o, lo_o      architectural HI / LO
//   busy_o          sequencer not idle
//   div_if          divider handshake (master side)
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int OP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid_i,
  input  logic [OP_W-1:0]     ex_op_i,
  input  logic [31:0]         ex_opr1_i,
  input  logic [31:0]         ex_opr2_i,
  input  logic                flush_i,
  input  logic                pipe_stall_i,
  output logic                ex_stallreq_o,
  output logic [31:0]         hi_o,
  output logic [31:0]         lo_o,
  output logic                busy_o,
  div_seq_ctrl_if.master      div_if
);

  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(3'd1);
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(3'd2);
  localparam logic [OP_W-1:0] OP_MTHI = OP_W'(3'd3);
  localparam logic [OP_W-1:0] OP_MTLO = OP_W'(3'd4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        div_start_q;
  logic        div_signdiv_q;
  logic        busy_q;
  logic [31:0] div_opr1_q;
  logic [31:0] div_opr2_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend_q;

  logic is_div_s;
  logic is_mthi_s;
  logic is_mtlo_s;

  // Operation decode of the instruction currently in EX.
  assign is_div_s  = ex_valid_i && ((ex_op_i == OP_DIV) || (ex_op_i == OP_DIVU));
  assign is_mthi_s = ex_valid_i && (ex_op_i == OP_MTHI);
  assign is_mtlo_s = ex_valid_i && (ex_op_i == OP_MTLO);

  // EX is held from the launch cycle until the result sits in DONE; DONE
  // releases EX so the completed divide can retire without relaunching.
  assign ex_stallreq_o = ((state_q == S_IDLE) && is_div_s && !flush_i) ||
                         (state_q == S_WAIT);

  assign div_if.div_abandon = flush_i && ((state_q == S_WAIT) || (state_q == S_DONE));
  // The divider freezes in its End state while the pipeline cannot accept the result.
  assign div_if.div_stall   = pipe_stall_i;
  assign div_if.div_start   = div_start_q;
  assign div_if.div_signdiv = div_signdiv_q;
  assign div_if.div_opr1    = div_opr1_q;
  assign div_if.div_opr2    = div_opr2_q;

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;

  // Sequencer FSM with registered start/busy, operand latches and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      div_start_q   <= 1'b0;
      div_signdiv_q <= 1'b0;
      busy_q        <= 1'b0;
      div_opr1_q    <= 32'd0;
      div_opr2_q    <= 32'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      pend_q        <= 64'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div_s && !flush_i) begin
            // Launch does not wait for pipe_stall: EX is held by ex_stallreq anyway.
            div_opr1_q    <= ex_opr1_i;
            div_opr2_q    <= ex_opr2_i;
            div_signdiv_q <= (ex_op_i == OP_DIV);
            div_start_q   <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_WAIT;
          end else if (is_mthi_s && !flush_i && !pipe_stall_i) begin
            hi_q <= ex_opr1_i;
          end else if (is_mtlo_s && !flush_i && !pipe_stall_i) begin
            lo_q <= ex_opr1_i;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          // Flush beats a simultaneous ready: nothing is captured.
          if (flush_i) begin
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 64'd0;
            state_q     <= S_IDLE;
          end else if (div_if.div_ready) begin
            pend_q      <= div_if.div_res;
            div_start_q <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            pend_q  <= 64'd0;
            state_q <= S_IDLE;
          end else if (!pipe_stall_i) begin
            hi_q    <= pend_q[63:32];
            lo_q    <= pend_q[31:0];
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_DONE;
          end
        end
        default: begin
          div_start_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;
  localparam int L = 35;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_opr1;
  logic [31:0] ex_opr2;
  logic        flush;
  logic        pipe_stall;
  logic        ex_stallreq;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  div_seq_ctrl_if dif();

  div_seq_ctrl #(.OP_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid),
    .ex_op_i      (ex_op),
    .ex_opr1_i    (ex_opr1),
    .ex_opr2_i    (ex_opr2),
    .flush_i      (flush),
    .pipe_stall_i (pipe_stall),
    .ex_stallreq_o(ex_stallreq),
    .hi_o         (hi),
    .lo_o         (lo),
    .busy_o       (busy),
    .div_if       (dif.master)
  );

  always #5 clk = ~clk;

  // Arithmetic result of the divider: {remainder, quotient}; x/0 gives 0/0.
  function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider stand-in: ready in the L-th consecutive cycle of start.
  int dv_cnt;
  always @(posedge clk) begin
    if (rst || !dif.div_start || dif.div_abandon) dv_cnt <= 0;
    else dv_cnt <= dv_cnt + 1;
  end
  assign dif.div_ready = dif.div_start && (dv_cnt == L - 1);
  assign dif.div_res   = dif.div_ready ?
                         div_calc(dif.div_opr1, dif.div_opr2, dif.div_signdiv) : 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a divide occupies L cycles after launch, then waits to retire.
  logic [31:0] m_hi, m_lo, m_opr1, m_opr2;
  logic        m_sign, m_done;
  logic [63:0] m_pend;
  int          m_left;
  logic        in_div;
  assign in_div = ex_valid && (ex_op == 3'd1 || ex_op == 3'd2);

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_opr1 <= 32'd0; m_opr2 <= 32'd0;
      m_sign <= 1'b0; m_done <= 1'b0; m_pend <= 64'd0; m_left <= 0;
    end else if (m_left > 0) begin
      if (flush) begin
        m_left <= 0; m_pend <= 64'd0;
      end else if (m_left == 1) begin
        m_left <= 0; m_done <= 1'b1; m_pend <= div_calc(m_opr1, m_opr2, m_sign);
      end else begin
        m_left <= m_left - 1;
      end
    end else if (m_done) begin
      if (flush) begin
        m_done <= 1'b0; m_pend <= 64'd0;
      end else if (!pipe_stall) begin
        m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; m_done <= 1'b0;
      end
    end else if (ex_valid && !flush) begin
      if (in_div) begin
        m_opr1 <= ex_opr1; m_opr2 <= ex_opr2; m_sign <= (ex_op == 3'd1); m_left <= L;
      end else if (!pipe_stall && ex_op == 3'd3) begin
        m_hi <= ex_opr1;
      end else if (!pipe_stall && ex_op == 3'd4) begin
        m_lo <= ex_opr1;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("ex_stallreq", {63'd0, ex_stallreq},
            {63'd0, (m_left > 0) || (m_left == 0 && !m_done && in_div && !flush)});
      check("div_start", {63'd0, dif.div_start}, {63'd0, m_left > 0});
      check("div_abandon", {63'd0, dif.div_abandon}, {63'd0, flush && (m_left > 0 || m_done)});
      check("div_stall", {63'd0, dif.div_stall}, {63'd0, pipe_stall});
      check("busy", {63'd0, busy}, {63'd0, (m_left > 0) || m_done});
      check("div_signdiv", {63'd0, dif.div_signdiv}, {63'd0, m_sign});
      check("div_opr1", {32'd0, dif.div_opr1}, {32'd0, m_opr1});
      check("div_opr2", {32'd0, dif.div_opr2}, {32'd0, m_opr2});
      check("hi", {32'd0, hi}, {32'd0, m_hi});
      check("lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  // Issue a divide, hold it in EX until it may leave; optionally stall DONE.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output int n);
    bit ok;
    int h;
    h = hold; n = 0; ok = 1'b0;
    ex_valid = 1'b1; ex_op = op; ex_opr1 = a; ex_opr2 = b;
    #1;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (ex_stallreq) n++;
      else if (h > 0) begin pipe_stall = 1'b1; h--; end
      else begin pipe_stall = 1'b0; ok = 1'b1; end
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; ex_op = 3'd0; pipe_stall = 1'b0;
    check("div_completes", {63'd0, ok}, 64'd1);
  endtask

  int n;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = 3'd0; ex_opr1 = 32'd0; ex_opr2 = 32'd0;
    flush = 1'b0; pipe_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_start", {63'd0, dif.div_start}, 64'd0);
    check("rst_opr1", {32'd0, dif.div_opr1}, 64'd0);

    run_div(3'd2, 32'd100, 32'd7, 0, n);
    check("divu_stall_cycles", 64'(n), 64'd36);
    check("divu_lo", {32'd0, lo}, 64'h0000_000E);
    check("divu_hi", {32'd0, hi}, 64'd2);

    run_div(3'd1, 32'hFFFF_FFF9, 32'd2, 0, n);
    check("div_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
    check("div_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});

    // Flush 10 cycles after launch.
    ex_valid = 1'b1; ex_op = 3'd1; ex_opr1 = 32'd77; ex_opr2 = 32'd5;
    #1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; ex_valid = 1'b0;
    #1;
    check("flush_abandon", {63'd0, dif.div_abandon}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; ex_op = 3'd0;
    #1;
    check("flush_idle", {63'd0, busy}, 64'd0);
    check("flush_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
    check("flush_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});

    run_div(3'd2, 32'd9, 32'd3, 0, n);
    check("divu93_lo", {32'd0, lo}, 64'd3);
    check("divu93_hi", {32'd0, hi}, 64'd0);

    run_div(3'd2, 32'd5, 32'd0, 0, n);
    check("div0_lo", {32'd0, lo}, 64'd0);
    check("div0_hi", {32'd0, hi}, 64'd0);

    run_div(3'd2, 32'd1000, 32'd33, 4, n);
    check("stall_done_cycles", 64'(n), 64'd36);
    check("stall_done_lo", {32'd0, lo}, 64'd30);
    check("stall_done_hi", {32'd0, hi}, 64'd10);

    // MTHI held one cycle by pipe_stall, then MTLO.
    ex_valid = 1'b1; ex_op = 3'd3; ex_opr1 = 32'h1234_5678; pipe_stall = 1'b1;
    #1;
    check("mthi_nostall", {63'd0, ex_stallreq}, 64'd0);
    @(posedge clk); #1;
    check("mthi_blocked", {32'd0, hi}, 64'd10);
    pipe_stall = 1'b0;
    @(posedge clk); #1;
    check("mthi_written", {32'd0, hi}, {32'd0, 32'h1234_5678});
    check("mthi_lo_kept", {32'd0, lo}, 64'd30);
    ex_op = 3'd4; ex_opr1 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    check("mtlo_written", {32'd0, lo}, {32'd0, 32'h9ABC_DEF0});
    ex_valid = 1'b0; ex_op = 3'd0;

    // Reset in the middle of a divide.
    ex_valid = 1'b1; ex_op = 3'd2; ex_opr1 = 32'd50; ex_opr2 = 32'd5;
    #1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; ex_valid = 1'b0; ex_op = 3'd0;
    @(posedge clk); #1;
    check("rst_mid_start", {63'd0, dif.div_start}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencer between the EX stage and the iterative `Divider`. It decodes divide and HI/LO-move operations and latches the operands. It drives the divider's `start`/`abandon`/`stall` handshake and stalls EX until the quotient and remainder are available. It owns the architectural HI/LO registers, which are committed only when the instruction leaves EX unflushed.

## Interface
Parameters:
- `OP_W`, 3: width of the `ex_op` operation code.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ex_valid`  in  1  a valid instruction is present in EX.
- `ex_op`  in  OP_W  operation code: 1 DIV, 2 DIVU, 3 MTHI, 4 MTLO; any other value is a no-op.
- `ex_opr1`  in  32  dividend, or the source value for MTHI/MTLO.
- `ex_opr2`  in  32  divisor.
- `flush`  in  1  exception or branch flush of EX.
- `pipe_stall`  in  1  downstream stall; EX cannot advance while high.
- `ex_stallreq`  out  1  EX stall request (combinational).
- `div_start`  out  1  divider `start`.
- `div_abandon`  out  1  divider `abandon` (combinational).
- `div_stall`  out  1  divider `stall`; equals `pipe_stall`.
- `div_signdiv`  out  1  divider `signdiv`.
- `div_opr1`  out  32  divider `opr1`, registered.
- `div_opr2`  out  32  divider `opr2`, registered.
- `div_ready`  in  1  divider `ready`.
- `div_res`  in  64  divider `res`: [63:32] remainder, [31:0] quotient.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Reset values: state IDLE; `hi`, `lo`, `div_opr1`, `div_opr2`, `div_signdiv`, `div_start`, `busy` all 0. The pending-result register is also 0.
- A divide op is `ex_valid` && `ex_op` ∈ {1,2}.
- The result (quotient/remainder) is passed through unmodified. Divide by zero yields whatever `div_res` returns, which is 0/0.

State IDLE:
- Divide op && !`flush`:
  - Latch `ex_opr1`→`div_opr1` and `ex_opr2`→`div_opr2`.
  - Set `div_signdiv` = (`ex_op`==1).
  - Go to WAIT.
  - This happens regardless of `pipe_stall`.
- MTHI/MTLO && !`flush` && !`pipe_stall`: write `ex_opr1` to `hi`/`lo` at the next edge. State stays IDLE.

State WAIT:
- `div_start`=1 continuously.
- `div_opr1`/`div_opr2`/`div_signdiv` are held stable; the divider uses them again for its sign fix-up.
- On `div_ready`: capture `div_res` into the pending register and go to DONE.

State DONE:
- `div_start`=0.
- If !`pipe_stall` && !`flush`: commit pending[63:32]→`hi` and pending[31:0]→`lo`, then go to IDLE.
- If `pipe_stall`: remain in DONE. The divider holds its End state because `div_stall`=1.

Combinational outputs:
- `ex_stallreq` = (IDLE && divide op && !`flush`) || WAIT.
  - In DONE it is 0, so the completed divide can leave EX.
  - DONE must never re-launch the same instruction.
- `div_abandon` = `flush` && (WAIT || DONE).

Flush:
- `flush` in WAIT or DONE → go to IDLE next edge.
- No HI/LO write; the pending register is cleared.
- `flush` in IDLE suppresses both launch and MTHI/MTLO.

Simultaneous events:
- `flush` and `div_ready` in the same cycle: `flush` wins; no capture, no commit.
- `rst` overrides everything, including `flush`.

## Timing
- Launch latency: the divide op is seen in IDLE at cycle 0; WAIT with `div_start`=1 begins at cycle 1.
- Divider latency L = start-to-ready, 35 cycles for this divider. The controller must not depend on L; it waits for `div_ready`.
- EX stall for a divide is 1+L cycles. DONE is entered on the edge after `div_ready`. HI/LO are visible one cycle after DONE is exited with !`pipe_stall`.
- MTHI/MTLO: `hi`/`lo` update on the edge they are accepted; no stall.
- Back-to-back divides: the second divide is launched only from IDLE, which is reached no earlier than one cycle after DONE. The divider has returned to Free by then because `div_start` is 0 and `div_stall` is 0.
- Reset mid-divide: state returns to IDLE with `div_start`=0. The divider keeps its own reset, which the top level asserts together with this block's reset.

## Test plan
- DIVU 100/7, no stalls → `ex_stallreq` high for 1+L cycles; then `lo`=14 (0x0000000E), `hi`=2.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 5/0 → completes through DONE; `lo`=0, `hi`=0; no hang.
- DIV in progress, `flush` pulsed 10 cycles after launch → `div_abandon`=1 for that cycle; state IDLE next; `hi`/`lo` unchanged. A new DIVU 9/3 afterwards gives `lo`=3, `hi`=0.
- `pipe_stall` held for 4 cycles in DONE → `hi`/`lo` unchanged until `pipe_stall` drops, then commit; no second launch.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive cycles, the first with `pipe_stall`=1 for one cycle → `hi` written only once the stall drops, `lo` on the following edge. `ex_stallreq` stays 0 throughout.
